// File: rtl/seq_input_conditioner_pkg.sv
// Shared types and board defaults for the NEXT/IN input conditioning stage.
package seq_input_conditioner_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } db_state_e;

    // 1,000,000 cycles is the default debounce window for the board build.
    localparam int BOARD_DEBOUNCE_CYCLES = 1000000;
    localparam int BOARD_SYNC_STAGES     = 2;
    localparam int BOARD_PRESS_W         = 8;

endpackage

// File: rtl/seq_input_conditioner_debounce_ch.sv
// One input channel: synchroniser chain followed by a counting debounce FSM.
//
//   state  | meaning
//   S_LOW  | level 0, input stable low
//   S_RISE | level 0, input high, counting toward acceptance
//   S_HIGH | level 1, input stable high
//   S_FALL | level 1, input low, counting toward release
module debounce_ch
    import seq_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = BOARD_SYNC_STAGES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   expired;

    assign s       = sync_q[SYNC_STAGES-1];
    assign expired = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            case (state_q)
                S_LOW: begin
                    if (s) begin
                        state_q <= S_RISE;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                S_RISE: begin
                    if (!s) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                    end else if (expired) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (!s) begin
                        state_q <= S_FALL;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                S_FALL: begin
                    if (s) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                    end else if (expired) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_LOW;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level = level_q;
    // Strobe for the acceptance edge; the top registers it so it lines up with level.
    assign rise  = (state_q == S_RISE) && s && expired;

endmodule

// File: rtl/seq_input_conditioner.sv
// Conditions the NEXT button and IN switch for the sequence detector and
// produces a press pulse plus a wrapping press counter for NEXT.
module seq_input_conditioner
    import seq_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = BOARD_SYNC_STAGES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1,
    parameter int PRESS_W         = BOARD_PRESS_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               next_raw,
    input  logic               in_raw,
    output logic               next_level,
    output logic               next_pulse,
    output logic               in_level,
    output logic [PRESS_W-1:0] press_count
);

    logic               next_rise;
    logic               in_rise_unused;
    logic               next_pulse_q;
    logic [PRESS_W-1:0] press_q;

    debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES),
        .CNT_W          (CNT_W)
    ) u_next (
        .clk  (clk),
        .reset(reset),
        .raw  (next_raw),
        .level(next_level),
        .rise (next_rise)
    );

    debounce_ch #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES),
        .CNT_W          (CNT_W)
    ) u_in (
        .clk  (clk),
        .reset(reset),
        .raw  (in_raw),
        .level(in_level),
        .rise (in_rise_unused)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_pulse_q <= 1'b0;
            press_q      <= '0;
        end else begin
            next_pulse_q <= next_rise;
            if (next_rise) begin
                press_q <= press_q + PRESS_W'(1);
            end
        end
    end

    assign next_pulse  = next_pulse_q;
    assign press_count = press_q;

endmodule

// File: tb/tb_seq_input_conditioner.sv
// Bench for seq_input_conditioner with a short debounce window and 3-bit press counter.
module tb_seq_input_conditioner;

    localparam int DB      = 4;
    localparam int SS      = 2;
    localparam int PW      = 3;
    localparam int LAT     = SS + DB;

    logic          clk;
    logic          reset;
    logic          next_raw;
    logic          in_raw;
    logic          next_level;
    logic          next_pulse;
    logic          in_level;
    logic [PW-1:0] press_count;

    seq_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .SYNC_STAGES    (SS),
        .PRESS_W        (PW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .next_raw   (next_raw),
        .in_raw     (in_raw),
        .next_level (next_level),
        .next_pulse (next_pulse),
        .in_level   (in_level),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [PW-1:0] cnt;
    } exp_t;

    typedef struct {
        logic n;
        logic i;
        int   hold;
        logic pulse;
        logic exp_nl;
        logic exp_il;
    } vec_t;

    exp_t          q[$];
    exp_t          e;
    vec_t          vecs[11];
    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] exp_cnt = '0;
    logic          prev_pulse = 1'b0;

    function automatic void check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Scoreboard: every pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse: got none expected at cycle %0d", q[0].cyc);
            void'(q.pop_front());
        end
        if (next_pulse) begin
            check("pulse_not_consecutive", int'(prev_pulse), 0);
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check("pulse_press_count", int'(press_count), int'(e.cnt));
                check("pulse_level", int'(next_level), 1);
            end else begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
            end
        end
        prev_pulse = next_pulse;
    end

    task automatic drive_hold(input logic n, input logic i, input int hold, input logic pulse);
        if (pulse) begin
            exp_cnt = exp_cnt + 1'b1;
            q.push_back('{cyc + LAT, exp_cnt});
        end
        next_raw = n;
        in_raw   = i;
        repeat (hold) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({next_level, in_level, next_pulse, press_count}), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_cnt = '0;
        #1;
        check_all_zero("reset_outputs");
        repeat (3) begin
            @(negedge clk);
            check_all_zero("reset_hold_outputs");
        end
        reset = 1'b1;
    endtask

    initial begin
        int k;
        vecs[0]  = '{1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 10, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3,  1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3,  1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3,  1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0};

        reset    = 1'b1;
        next_raw = 1'b0;
        in_raw   = 1'b0;
        #2;
        @(negedge clk);
        do_reset();
        repeat (6) begin
            @(negedge clk);
            check_all_zero("post_reset_idle");
        end

        // Level/latency/glitch vectors; pulses verified by the scoreboard.
        for (int v = 0; v < 11; v++) begin
            drive_hold(vecs[v].n, vecs[v].i, vecs[v].hold, vecs[v].pulse);
            check($sformatf("vec%0d_next_level", v), int'(next_level), int'(vecs[v].exp_nl));
            check($sformatf("vec%0d_in_level", v), int'(in_level), int'(vecs[v].exp_il));
        end

        // Nine clean presses from a fresh reset: counter wraps 7 -> 0.
        @(negedge clk);
        do_reset();
        @(negedge clk);
        for (int p = 0; p < 9; p++) begin
            drive_hold(1'b1, 1'b0, 8, 1'b1);
            check($sformatf("press%0d_count", p), int'(press_count), (p + 1) % 8);
            drive_hold(1'b0, 1'b0, 8, 1'b0);
            check($sformatf("press%0d_released", p), int'(next_level), 0);
        end

        // Button held while reset hits mid-debounce (cnt==2).
        next_raw = 1'b1;
        repeat (4) @(negedge clk);
        do_reset();
        q.push_back('{cyc + LAT, exp_cnt + 1'b1});
        exp_cnt = exp_cnt + 1'b1;
        repeat (10) @(negedge clk);
        check("held_reset_level", int'(next_level), 1);
        check("held_reset_count", int'(press_count), 1);

        // Simultaneous rise on both channels.
        drive_hold(1'b0, 1'b0, 10, 1'b0);
        k = cyc;
        q.push_back('{k + LAT, exp_cnt + 1'b1});
        exp_cnt = exp_cnt + 1'b1;
        next_raw = 1'b1;
        in_raw   = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        check("simul_before", int'({next_level, in_level}), 0);
        @(negedge clk);
        check("simul_levels", int'({next_level, in_level, next_pulse}), 7);

        repeat (10) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
